// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key-value constants and the key decode
// function for the matrix-keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } keypad_state_t;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_A    = 4'd12;
    localparam logic [3:0] KEY_B    = 4'd13;
    localparam logic [3:0] KEY_C    = 4'd14;
    localparam logic [3:0] KEY_D    = 4'd15;

    // Phone-style layout for 3- and 4-column pads; the fourth column
    // carries A..D. Anything else falls back to the raw index.
    function automatic logic [3:0] key_decode(
        input int unsigned idx,
        input int unsigned cols
    );
        int unsigned r;
        int unsigned c;
        int unsigned i3;
        logic [3:0]  v;
        r  = idx / cols;
        c  = idx % cols;
        i3 = r * 3 + c;
        v  = 4'(idx);
        if ((cols == 3 || cols == 4) && r < 4) begin
            if (c == 3) begin
                case (r)
                    0:       v = KEY_A;
                    1:       v = KEY_B;
                    2:       v = KEY_C;
                    default: v = KEY_D;
                endcase
            end else if (i3 < 9) begin
                v = 4'(i3 + 1);
            end else if (i3 == 9) begin
                v = KEY_STAR;
            end else if (i3 == 10) begin
                v = 4'd0;
            end else begin
                v = KEY_HASH;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: key-event bundle from the scanner to the entry logic.
// key_valid/key_idx/key_value/key_held/multi_err; master drives them.
interface keypad_if #(
    parameter int ROWS = 4,
    parameter int COLS = 3
);
    localparam int IDX_W = $clog2(ROWS * COLS);

    logic             key_valid;
    logic [IDX_W-1:0] key_idx;
    logic [3:0]       key_value;
    logic             key_held;
    logic             multi_err;

    modport master (
        output key_valid, key_idx, key_value, key_held, multi_err
    );

    modport slave (
        input key_valid, key_idx, key_value, key_held, multi_err
    );

endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: W-bit two-flop synchroniser, resets to all-ones.
// Ports: clk, rst_n (async, active-low), d (async in), q (synced out).
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '1;
            q  <= '1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobed keypad scan with press/release
// debounce. Ports: clk, rst_n, row_n (async rows), col_n (one-hot-low
// strobes), kif (keypad_if.master key events). Auto-repeat in HELD is
// built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_RATE     = 100000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col_n,
    keypad_if.master        kif
);

    localparam int IDX_W = $clog2(ROWS * COLS);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int DW    = $clog2(SCAN_DIV);
    localparam int BW    = $clog2(DEBOUNCE_CYCLES);

    if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 ||
        SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 ||
        REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_cfg
        $error("keypad_scanner: parameter out of range");
    end

    keypad_state_t    state;
    keypad_state_t    state_nx;
    logic [ROWS-1:0]  rs;
    logic [ROWS-1:0]  low;
    logic [ROWS-1:0]  pat;
    logic [RW-1:0]    rsel;
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    c;
    logic [DW-1:0]    dcnt;
    logic [BW-1:0]    bcnt;
    logic [IDX_W-1:0] idx_n;
    logic             sample;
    logic             all_high;
    logic             one_low;
    logic             match;
    logic             deb_done;
    logic             rel_done;
    logic             rep_fire;
    logic             adv;
    logic             evt;
    logic             err;

    keypad_sync #(.W(ROWS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (rs)
    );

    assign low      = ~rs;
    assign all_high = &rs;
    assign one_low  = !all_high && ((low & (low - 1'b1)) == '0);
    assign match    = (rs == pat);
    assign sample   = (state == SCAN) && (dcnt == DW'(SCAN_DIV - 1));
    assign deb_done = (state == DEBOUNCE) && match &&
                      (bcnt == BW'(DEBOUNCE_CYCLES - 1));
    assign rel_done = (state == RELEASE) && all_high &&
                      (bcnt == BW'(DEBOUNCE_CYCLES - 1));
    assign idx_n    = IDX_W'(int'(row_q) * COLS + int'(c));
    assign col_n    = ~(COLS'(1) << c);

    always_comb begin
        rsel = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (low[i]) rsel = RW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SCAN;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SCAN:     if (sample && one_low) state_nx = DEBOUNCE;
            DEBOUNCE: begin
                if (!match)        state_nx = SCAN;
                else if (deb_done) state_nx = HELD;
            end
            HELD:     if (all_high) state_nx = RELEASE;
            RELEASE:  if (rel_done) state_nx = SCAN;
            default:  state_nx = SCAN;
        endcase
    end

    always_comb begin
        adv = (sample && !one_low) ||
              (state == DEBOUNCE && !match) ||
              rel_done;
        evt = deb_done || rep_fire;
        err = sample && !all_high && !one_low;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                          REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW  = $clog2(RMAX + 1);

    logic [RPW-1:0] rcnt;
    logic [RPW-1:0] rlim;
    logic           rfirst;

    // rcnt counts cycles since the last pulse; the first gap is longer.
    assign rlim     = rfirst ? RPW'(REPEAT_DELAY - 1) :
                               RPW'(REPEAT_RATE - 1);
    assign rep_fire = (state == HELD) && !all_high && (rcnt == rlim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt   <= '0;
            rfirst <= 1'b1;
        end else if (state != HELD) begin
            rcnt   <= '0;
            rfirst <= 1'b1;
        end else if (rep_fire) begin
            rcnt   <= '0;
            rfirst <= 1'b0;
        end else begin
            rcnt   <= rcnt + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c             <= '0;
            dcnt          <= '0;
            bcnt          <= '0;
            pat           <= '1;
            row_q         <= '0;
            kif.key_valid <= 1'b0;
            kif.multi_err <= 1'b0;
            kif.key_held  <= 1'b0;
            kif.key_idx   <= '0;
            kif.key_value <= '0;
        end else begin
            kif.key_valid <= evt;
            kif.multi_err <= err;
            if (adv) c <= (c == CW'(COLS - 1)) ? '0 : c + 1'b1;
            dcnt <= (state == SCAN && !sample) ? dcnt + 1'b1 : '0;
            if (sample && one_low) begin
                pat   <= rs;
                row_q <= rsel;
            end
            // One counter serves both press and release runs.
            if ((state == DEBOUNCE && match && !deb_done) ||
                (state == RELEASE && all_high && !rel_done))
                bcnt <= bcnt + 1'b1;
            else
                bcnt <= '0;
            if (deb_done) begin
                kif.key_idx   <= idx_n;
                kif.key_value <= key_decode(32'(idx_n), COLS);
                kif.key_held  <= 1'b1;
            end else if (rel_done) begin
                kif.key_held  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner for a ROWS×COLS keypad. The block drives one column low at a time and samples the rows through a synchroniser. It debounces both press and release, then emits a one-cycle key event carrying the raw key index and the decoded key value. It sits between the keypad pins and the digit-entry/control logic, and replaces the purely combinational row/column decode.

## Interface
- ROWS, default 4: number of keypad rows (2–8).
- COLS, default 3: number of keypad columns (2–8).
- SCAN_DIV, default 16: cycles each column is driven before its rows are sampled (≥4).
- DEBOUNCE_CYCLES, default 1024: consecutive stable samples required to accept a press or a release (≥2).
- REPEAT_DELAY, default 500000: cycles from the first event to the first auto-repeat (used only with the macro).
- REPEAT_RATE, default 100000: cycles between auto-repeats (used only with the macro).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- row_n  in  ROWS  keypad rows. Asynchronous, active-low, externally pulled up.
- col_n  out  COLS  column strobes, active-low one-hot.
- key_valid  out  1  one-cycle pulse per accepted key event.
- key_idx  out  $clog2(ROWS*COLS)  row*COLS+col of the last accepted key.
- key_value  out  4  decoded value of the last accepted key.
- key_held  out  1  high from the key_valid cycle until the release is debounced.
- multi_err  out  1  one-cycle pulse when more than one row is low in the sampled column.

## Operation
- row_n passes through a 2-flop synchroniser. All decisions use the synchronised vector `rs`.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- **SCAN**
  - Drive column c for SCAN_DIV cycles, then sample `rs` on the last dwell cycle.
  - All rows high: advance c, wrapping COLS-1→0.
  - Exactly one row r low: latch (r,c) and go to DEBOUNCE with c frozen.
  - Two or more rows low: pulse multi_err, advance c, no event.
- **DEBOUNCE**
  - Count consecutive cycles where `rs` equals the latched one-hot pattern.
  - Any mismatch: return to SCAN at column c+1.
  - Count reaches DEBOUNCE_CYCLES: register key_idx and key_value, pulse key_valid, set key_held, go to HELD.
- **HELD**: stay while the pattern persists. When `rs` is all-high, go to RELEASE.
- **RELEASE**
  - Count consecutive all-high cycles. Any low row restarts the count.
  - Count reaches DEBOUNCE_CYCLES: clear key_held, go to SCAN at column c+1.
- Decode of key_value:
  - For COLS≥3, idx 0..8 maps to 1..9.
  - idx 9 ('*') maps to 10, idx 10 maps to 0, idx 11 ('#') maps to 11.
  - For COLS=4 the fourth column decodes rows 0..3 as 12..15 (A–D), and the 3-column map applies to the first three columns.
  - Any other geometry: key_value = key_idx[3:0].
- key_idx and key_value hold their value until the next event.
- Reset values:
  - State SCAN, c=0, col_n = ~1 (column 0 low).
  - All counters 0.
  - key_valid, key_held, multi_err = 0.
  - key_idx, key_value = 0.
- Reset asserted mid-operation aborts any count and produces no event.

## Timing
- Synchroniser latency is 2 cycles. SCAN_DIV≥4 guarantees rows settle and propagate before sampling.
- Full scan period is COLS*SCAN_DIV cycles.
- key_valid rises on the edge after the DEBOUNCE_CYCLES-th matching sample. key_idx and key_value are valid in the same cycle.
- key_valid is never asserted on two consecutive cycles.
- multi_err and key_valid are mutually exclusive in any cycle.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, after REPEAT_DELAY cycles, pulse key_valid again with the same key_idx and key_value.
  - Repeat every REPEAT_RATE cycles after that while held.
  - Leaving HELD cancels the repeat counter.
- Macro undefined: exactly one key_valid per press, and no repeat counter is synthesised.

## Structure
- Package keypad_pkg holds:
  - the state enum `keypad_state_t`;
  - key-value constants KEY_STAR=10, KEY_HASH=11, KEY_A..KEY_D=12..15;
  - function `key_decode(idx, cols)` returning the 4-bit value.
- Sub-module keypad_sync: parametrised-width 2-flop synchroniser with async active-low reset, reset value all-ones.
- Column rotation, counters and the FSM live in keypad_scanner.

## Test plan
Default parameters for all scenarios: ROWS=4, COLS=3, SCAN_DIV=4, DEBOUNCE_CYCLES=8.
- Reset, then no key for 24 cycles → col_n cycles 110, 101, 011 every 4 cycles; no key_valid.
- Hold row 1 low while column 2 is driven, clean, for 40 cycles → one key_valid with key_idx=5, key_value=6; key_held stays high until 8 cycles after release.
- Press row 3 / column 0 with bounce (low 3 cycles, high 1, then stable) → exactly one key_valid with key_value=10; no event during the bounce.
- Rows 0 and 2 both low on column 1 → multi_err pulse, no key_valid, scanning continues.
- Row 3 / column 1 pressed, reset asserted at debounce count 5 → no key_valid; all outputs at reset values; after re-scan the key is accepted with key_value=0.
- KEYPAD_REPEAT_EN with REPEAT_DELAY=50, REPEAT_RATE=20, key held 120 cycles → key_valid at the event cycle, +50, +70, +90, +110, then no further pulses.
